// File: rtl/mod100_pkg.sv
// mod100_pkg: shared constants, FSM state type and input clamp helper for the mod-N down counter.
//   MOD_DEFAULT - default wrap modulus
//   state_t     - IDLE / COUNT / DONE
//   clamp()     - limits an 8-bit input to 0..m-1
package mod100_pkg;
    localparam int MOD_DEFAULT = 100;
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
    function automatic logic [7:0] clamp(input logic [7:0] v, input int m);
        return ({24'd0, v} >= m) ? 8'(m - 1) : v;
    endfunction
endpackage

// File: rtl/mod100_down_counter_if.sv
// mod100_down_counter_if: control/data bundle of the mod-N down counter.
//   master: drives start, load_value, tick, step, borrow_in, ack; observes value, borrow_out, busy, done
//   slave : the counter side (opposite directions)
interface mod100_down_counter_if;
    logic       start;
    logic [7:0] load_value;
    logic       tick;
    logic [7:0] step;
    logic       borrow_in;
    logic       ack;
    logic [7:0] value;
    logic       borrow_out;
    logic       busy;
    logic       done;
    modport master (output start, load_value, tick, step, borrow_in, ack,
                    input  value, borrow_out, busy, done);
    modport slave  (input  start, load_value, tick, step, borrow_in, ack,
                    output value, borrow_out, busy, done);
endinterface

// File: rtl/mod100_sub.sv
// mod100_sub: combinational modular subtract, value - step_c - borrow_in wrapped into 0..MODULUS-1.
//   value, step_c : operands already in 0..MODULUS-1
//   borrow_in     : extra 1 subtracted
//   next_value    : wrapped difference
//   wrap          : difference went negative and was corrected
module mod100_sub
    import mod100_pkg::*;
#(
    parameter int MODULUS = MOD_DEFAULT
) (
    input  logic [7:0] value,
    input  logic [7:0] step_c,
    input  logic       borrow_in,
    output logic [7:0] next_value,
    output logic       wrap
);
    // Operands stay below 128 so the 9-bit difference never overflows; bit 8 is the sign.
    logic [8:0] d;
    logic [8:0] d_fix;
    always_comb begin
        d          = {1'b0, value} - {1'b0, step_c} - {8'd0, borrow_in};
        d_fix      = d + 9'(MODULUS);
        wrap       = d[8];
        next_value = wrap ? d_fix[7:0] : d[7:0];
    end
endmodule

// File: rtl/mod100_down_counter.sv
// mod100_down_counter: loadable mod-N decimal down counter that stops after MAX_WRAPS borrows.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mod100_down_counter_if (start/load_value/tick/step/borrow_in/ack in,
//                value/borrow_out/busy/done out)
//   Build option MOD100_SAT_EN: saturate at 0 instead of wrapping and stop on underflow or on reaching 0.
module mod100_down_counter
    import mod100_pkg::*;
#(
    parameter int MODULUS   = MOD_DEFAULT,
    parameter int MAX_WRAPS = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mod100_down_counter_if.slave          bus
);
    state_t     state, state_n;
    logic [7:0] value_q, value_n;
    logic [3:0] wrap_cnt, wrap_cnt_n;
    logic       borrow_q, borrow_n;
    logic [7:0] sub_value;
    logic       sub_wrap;

    mod100_sub #(.MODULUS(MODULUS)) u_sub (
        .value      (value_q),
        .step_c     (clamp(bus.step, MODULUS)),
        .borrow_in  (bus.borrow_in),
        .next_value (sub_value),
        .wrap       (sub_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            value_q  <= '0;
            wrap_cnt <= '0;
            borrow_q <= 1'b0;
        end else begin
            state    <= state_n;
            value_q  <= value_n;
            wrap_cnt <= wrap_cnt_n;
            borrow_q <= borrow_n;
        end
    end

    // start takes priority in every state, so a reload always beats a tick or an ack.
    always_comb begin
        state_n    = state;
        value_n    = value_q;
        wrap_cnt_n = wrap_cnt;
        borrow_n   = 1'b0;
        if (bus.start) begin
            state_n    = COUNT;
            value_n    = clamp(bus.load_value, MODULUS);
            wrap_cnt_n = '0;
        end else if (state == COUNT && bus.tick) begin
            borrow_n = sub_wrap;
`ifdef MOD100_SAT_EN
            value_n = sub_wrap ? 8'd0 : sub_value;
            state_n = (sub_wrap || sub_value == 8'd0) ? DONE : COUNT;
`else
            value_n = sub_value;
            if (sub_wrap) begin
                wrap_cnt_n = wrap_cnt + 4'd1;
                state_n    = (wrap_cnt + 4'd1 == 4'(MAX_WRAPS)) ? DONE : COUNT;
            end
`endif
        end else if (state == DONE && bus.ack) begin
            state_n = IDLE;
        end
    end

    always_comb begin
        bus.value      = value_q;
        bus.borrow_out = borrow_q;
        bus.busy       = (state == COUNT);
        bus.done       = (state == DONE);
    end
endmodule

// File: tb/tb_mod100_down_counter.sv
// tb_mod100_down_counter: directed self-checking bench for mod100_down_counter (MODULUS=100, MAX_WRAPS=1).
module tb_mod100_down_counter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mod100_down_counter_if bus();

    mod100_down_counter #(.MODULUS(100), .MAX_WRAPS(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [7:0] v, input logic b,
                              input logic bz, input logic d);
        checks++;
        if (bus.value !== v || bus.borrow_out !== b || bus.busy !== bz || bus.done !== d) begin
            errors++;
            $display("FAIL %s: got value=%0d borrow=%b busy=%b done=%b, want value=%0d borrow=%b busy=%b done=%b",
                     name, bus.value, bus.borrow_out, bus.busy, bus.done, v, b, bz, d);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b1; bus.load_value = 8'd7; bus.tick = 1'b0;
        bus.step = 8'd0; bus.borrow_in = 1'b0; bus.ack = 1'b0;
        cycle(); cycle();
        expect_out("reset", 8'd0, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b0;
        rst_n = 1'b1;
        cycle();
        expect_out("reset_idle", 8'd0, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1; bus.load_value = 8'd7;
        cycle();
        bus.start = 1'b0;
        expect_out("start_load7", 8'd7, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_count();
        bus.start = 1'b1; bus.load_value = 8'd10; bus.step = 8'd3;
        cycle();
        bus.start = 1'b0; bus.tick = 1'b1;
        cycle(); expect_out("count_7", 8'd7, 1'b0, 1'b1, 1'b0);
        cycle(); expect_out("count_4", 8'd4, 1'b0, 1'b1, 1'b0);
        cycle(); expect_out("count_1", 8'd1, 1'b0, 1'b1, 1'b0);
        cycle(); expect_out("count_wrap98", 8'd98, 1'b1, 1'b0, 1'b1);
        cycle(); expect_out("done_frozen", 8'd98, 1'b0, 1'b0, 1'b1);
        bus.tick = 1'b0; bus.ack = 1'b1;
        cycle(); expect_out("ack_idle", 8'd98, 1'b0, 1'b0, 1'b0);
        bus.ack = 1'b0; bus.tick = 1'b1; bus.step = 8'd5; bus.borrow_in = 1'b1;
        cycle(); expect_out("tick_ignored_idle", 8'd98, 1'b0, 1'b0, 1'b0);
        bus.tick = 1'b0; bus.borrow_in = 1'b0; bus.ack = 1'b1;
        cycle(); expect_out("ack_ignored_idle", 8'd98, 1'b0, 1'b0, 1'b0);
        bus.ack = 1'b0;
    endtask

    task automatic test_borrow_chain();
        bus.start = 1'b1; bus.load_value = 8'd0; bus.step = 8'd0;
        cycle();
        bus.start = 1'b0; bus.tick = 1'b1;
        cycle(); expect_out("step0_hold", 8'd0, 1'b0, 1'b1, 1'b0);
        bus.borrow_in = 1'b1;
        cycle(); expect_out("borrow_in_wrap99", 8'd99, 1'b1, 1'b0, 1'b1);
        bus.tick = 1'b0; bus.borrow_in = 1'b0;
        cycle(); expect_out("borrow_one_cycle", 8'd99, 1'b0, 1'b0, 1'b1);
        bus.ack = 1'b1;
        cycle();
        bus.ack = 1'b0;
    endtask

    task automatic test_clamp();
        bus.start = 1'b1; bus.load_value = 8'd150; bus.step = 8'd200;
        cycle();
        bus.start = 1'b0;
        expect_out("clamp_load99", 8'd99, 1'b0, 1'b1, 1'b0);
        bus.tick = 1'b1;
        cycle(); expect_out("clamp_step_to0", 8'd0, 1'b0, 1'b1, 1'b0);
        bus.tick = 1'b0;
    endtask

    task automatic test_start_precedence();
        bus.start = 1'b1; bus.load_value = 8'd50; bus.tick = 1'b1; bus.step = 8'd3;
        cycle(); expect_out("start_beats_tick", 8'd50, 1'b0, 1'b1, 1'b0);
        bus.start = 1'b0; bus.step = 8'd60;
        cycle(); expect_out("wrap_90", 8'd90, 1'b1, 1'b0, 1'b1);
        bus.tick = 1'b0; bus.start = 1'b1; bus.ack = 1'b1; bus.load_value = 8'd20;
        cycle(); expect_out("start_beats_ack", 8'd20, 1'b0, 1'b1, 1'b0);
        bus.start = 1'b0; bus.ack = 1'b0;
    endtask

    task automatic test_saturation();
        bus.start = 1'b1; bus.load_value = 8'd5; bus.step = 8'd9;
        cycle();
        bus.start = 1'b0; bus.tick = 1'b1;
        cycle(); expect_out("sat_underflow", 8'd0, 1'b1, 1'b0, 1'b1);
        bus.tick = 1'b0; bus.ack = 1'b1;
        cycle();
        bus.ack = 1'b0; bus.start = 1'b1; bus.load_value = 8'd6; bus.step = 8'd3;
        cycle();
        bus.start = 1'b0; bus.tick = 1'b1;
        cycle(); expect_out("sat_3", 8'd3, 1'b0, 1'b1, 1'b0);
        cycle(); expect_out("sat_exact0", 8'd0, 1'b0, 1'b0, 1'b1);
        bus.tick = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.start = 1'b1; bus.load_value = 8'd40; bus.step = 8'd1;
        cycle();
        bus.start = 1'b0; bus.tick = 1'b1;
        cycle(); expect_out("pre_reset_39", 8'd39, 1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 expect_out("async_reset", 8'd0, 1'b0, 1'b0, 1'b0);
        bus.tick = 1'b0;
        cycle();
        expect_out("reset_held", 8'd0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
`ifdef MOD100_SAT_EN
        test_saturation();
`else
        test_count();
        test_borrow_chain();
        test_clamp();
        test_start_precedence();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
